// File: rtl/div8_seq.sv
// div8_seq: iterative restoring divider, one quotient bit per clock.
// Signed mode divides magnitudes, then fixes signs in a final cycle.
module div8_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             dz,
   output logic             of
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             sg;
   logic             zero;
   logic [WIDTH-1:0] xl;
   logic [WIDTH-1:0] yl;
   logic [WIDTH-1:0] ym;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;

   logic             accept;
   logic [WIDTH-1:0] xmag;
   logic [WIDTH-1:0] ymag;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] restore;
   logic             negq;
   logic             negr;
   logic             ovf;

   assign busy   = (state == RUN) || (state == FIX);
   assign done   = (state == DONE);
   assign accept = start && ((state == IDLE) || (state == DONE));

   // 0x80 magnitude is 128, which still fits WIDTH unsigned bits
   assign xmag = (sign && x[WIDTH-1]) ? -x : x;
   assign ymag = (sign && y[WIDTH-1]) ? -y : y;

   assign trial   = {rem, quo[WIDTH-1]} - {1'b0, ym};
   assign restore = {rem[WIDTH-2:0], quo[WIDTH-1]};

   assign negq = sg && (xl[WIDTH-1] ^ yl[WIDTH-1]);
   assign negr = sg && xl[WIDTH-1];
   assign ovf  = sg && (xl == MINV) && (yl == ONES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sg    <= 1'b0;
         zero  <= 1'b0;
         xl    <= '0;
         yl    <= '0;
         ym    <= '0;
         rem   <= '0;
         quo   <= '0;
         q     <= '0;
         r     <= '0;
         dz    <= 1'b0;
         of    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  sg    <= sign;
                  xl    <= x;
                  yl    <= y;
                  ym    <= ymag;
                  rem   <= '0;
                  quo   <= xmag;
                  cnt   <= CW'(WIDTH - 1);
                  zero  <= (y == '0);
                  dz    <= 1'b0;
                  of    <= 1'b0;
                  // zero divisor skips the loop but still spends one busy cycle
                  state <= (y == '0) ? FIX : RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               rem <= trial[WIDTH] ? restore : trial[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (zero) begin
                  q  <= ONES;
                  r  <= xl;
                  dz <= 1'b1;
                  of <= 1'b0;
               end else begin
                  q  <= negq ? -quo : quo;
                  r  <= negr ? -rem : rem;
                  dz <= 1'b0;
                  of <= ovf;
               end
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
